// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI responder: oversampled SCLK/CS_n/MOSI, full-duplex 8-bit frames
module spi_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic       clock_pol_i,
    input  logic       clock_pha_i,
    input  logic       bit_order_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       overrun_o,
    output logic       underrun_o,
    output logic       busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [1:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_tx_shift;
    logic [7:0] r_rx_shift;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_overrun;
    logic       r_underrun;

    logic       w_sclk;
    logic       w_cs_n;
    logic       w_mosi;
    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_cs_fall;
    logic       w_tx_fire;
    logic       w_tx_bit;
    logic [7:0] w_rx_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead    = (r_sclk_d == clock_pol_i) && (w_sclk != clock_pol_i);
    assign w_trail   = (r_sclk_d != clock_pol_i) && (w_sclk == clock_pol_i);
    assign w_sample  = clock_pha_i ? w_trail : w_lead;
    assign w_shift   = clock_pha_i ? w_lead : w_trail;
    assign w_cs_fall = r_cs_d && !w_cs_n;
    assign w_tx_fire = tx_valid_i && !r_hold_full;
    assign w_tx_bit  = bit_order_i ? r_tx_shift[0] : r_tx_shift[7];
    assign w_rx_next = bit_order_i ? {w_mosi, r_rx_shift[7:1]} : {r_rx_shift[6:0], w_mosi};

    // Shift edges are ignored while the bit counter is 0: this skips the CPHA=1 first
    // leading edge and the CPHA=0 trailing edge that follows a byte-boundary reload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_tx_shift  <= IDLE_FILL;
            r_rx_shift  <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            if (w_tx_fire) begin
                r_hold      <= tx_data_i;
                r_hold_full <= 1'b1;
            end
            if (rx_ack_i && r_rx_valid) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_cs_n) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (r_hold_full) begin
                            r_tx_shift  <= r_hold;
                            r_hold_full <= 1'b0;
                        end else begin
                            r_tx_shift <= IDLE_FILL;
                            r_underrun <= 1'b1;
                        end
                        r_bit_cnt  <= 3'd0;
                        r_rx_shift <= 8'h00;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_cs_n) begin
                        r_state <= S_IDLE;
                    end else if (w_sample) begin
                        r_rx_shift <= w_rx_next;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_overrun  <= r_rx_valid && !rx_ack_i;
                            r_state    <= S_LOAD;
                        end
                    end else if (w_shift && (r_bit_cnt != 3'd0)) begin
                        r_tx_shift <= bit_order_i ? {1'b1, r_tx_shift[7:1]}
                                                  : {r_tx_shift[6:0], 1'b1};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign miso_o     = (r_state == S_IDLE) ? 1'b1 : w_tx_bit;
    assign miso_oe_o  = (r_state != S_IDLE);
    assign busy_o     = (r_state != S_IDLE);
    assign tx_ready_o = !r_hold_full;
    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign overrun_o  = r_overrun;
    assign underrun_o = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave with an RX scoreboard queue
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso_o;
    logic       miso_oe_o;
    logic       cpol;
    logic       cpha;
    logic       order;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ack;
    logic       overrun_o;
    logic       underrun_o;
    logic       busy_o;

    int         n_err;
    int         n_chk;
    int         n_over;
    int         n_under;
    logic       prev_valid;
    logic [7:0] exp_rx[$];

    spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sclk_i      (sclk),
        .cs_n_i      (cs_n),
        .mosi_i      (mosi),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o),
        .clock_pol_i (cpol),
        .clock_pha_i (cpha),
        .bit_order_i (order),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready_o),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ack_i    (rx_ack),
        .overrun_o   (overrun_o),
        .underrun_o  (underrun_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Byte completions are recognised by rx_valid rising or an overrun pulse.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            if (overrun_o)  n_over++;
            if (underrun_o) n_under++;
            if ((rx_valid_o && !prev_valid) || overrun_o) begin
                chk("rx_byte_expected", (exp_rx.size() > 0), 1'b1);
                if (exp_rx.size() > 0) begin
                    e = exp_rx.pop_front();
                    chk("rx_data", rx_data_o, e);
                end
            end
        end
        prev_valid = rx_valid_o;
    end

    task automatic write_tx(input logic [7:0] d);
        int k;
        k = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready_o && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("tx_accept", tx_ready_o, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_drop", tx_ready_o, 1'b0);
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        chk("rx_valid_cleared", rx_valid_o, 1'b0);
    endtask

    task automatic cs_low();
        sclk = cpol;
        wait_clk(8);
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        wait_clk(8);
        cs_n = 1'b1;
        wait_clk(16);
    endtask

    // Master side at clk/16: half SCLK period = 8 system clocks.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int idx;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = order ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[idx];
                wait_clk(8);
                sclk = ~cpol;
                mi[idx] = miso_o;
                wait_clk(8);
                sclk = cpol;
            end else begin
                wait_clk(8);
                sclk = ~cpol;
                mosi = mo[idx];
                wait_clk(8);
                sclk = cpol;
                mi[idx] = miso_o;
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        int         u0;
        n_err = 0; n_chk = 0; n_over = 0; n_under = 0; prev_valid = 1'b0;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; order = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b0;
        wait_clk(3);
        chk("rst_miso", miso_o, 1'b1);
        chk("rst_miso_oe", miso_oe_o, 1'b0);
        chk("rst_tx_ready", tx_ready_o, 1'b1);
        chk("rst_rx_data", rx_data_o, 8'h00);
        chk("rst_rx_valid", rx_valid_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_underrun", underrun_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        rst = 1'b0;
        wait_clk(8);

        // Mode 0, MSB first
        write_tx(8'h3C);
        exp_rx.push_back(8'hA5);
        u0 = n_under;
        cs_low();
        chk("m0_busy", busy_o, 1'b1);
        chk("m0_oe", miso_oe_o, 1'b1);
        chk("m0_first_bit", miso_o, 1'b0);
        chk("m0_no_underrun", n_under - u0, 0);
        xfer(8'hA5, 8, mi);
        cs_high();
        chk("m0_miso_byte", mi, 8'h3C);
        chk("m0_rx_valid", rx_valid_o, 1'b1);
        chk("idle_miso", miso_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);
        ack_rx();

        // Mode 3, LSB first
        cpol = 1'b1; cpha = 1'b1; order = 1'b1;
        sclk = 1'b1;
        wait_clk(8);
        write_tx(8'h81);
        exp_rx.push_back(8'h0F);
        cs_low();
        xfer(8'h0F, 8, mi);
        cs_high();
        chk("m3_miso_byte", mi, 8'h81);
        chk("m3_rx_valid", rx_valid_o, 1'b1);
        ack_rx();

        // Two bytes in one CS, second TX written after the first load, RX not acked
        cpol = 1'b0; cpha = 1'b0; order = 1'b0;
        sclk = 1'b0;
        wait_clk(8);
        write_tx(8'hAA);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        u0 = n_over;
        cs_low();
        write_tx(8'hBB);
        xfer(8'h11, 8, mi);
        xfer(8'h22, 8, mi2);
        cs_high();
        chk("b2b_miso_byte1", mi, 8'hAA);
        chk("b2b_miso_byte2", mi2, 8'hBB);
        chk("b2b_overrun_count", n_over - u0, 1);
        chk("b2b_rx_data", rx_data_o, 8'h22);
        ack_rx();

        // Mode 1 with nothing queued: underrun and idle fill
        cpha = 1'b1;
        wait_clk(8);
        u0 = n_under;
        exp_rx.push_back(8'h96);
        cs_low();
        chk("ur_pulse_at_load", n_under - u0, 1);
        xfer(8'h96, 8, mi);
        cs_high();
        chk("ur_miso_fill", mi, 8'hFF);
        chk("ur_tx_ready", tx_ready_o, 1'b1);
        ack_rx();

        // Partial frame discarded, then a full frame
        cpha = 1'b0;
        wait_clk(8);
        u0 = n_over;
        cs_low();
        xfer(8'hFF, 5, mi);
        cs_high();
        chk("partial_no_rx_valid", rx_valid_o, 1'b0);
        chk("partial_no_overrun", n_over - u0, 0);
        exp_rx.push_back(8'h5A);
        cs_low();
        xfer(8'h5A, 8, mi);
        cs_high();
        chk("after_partial_rx_data", rx_data_o, 8'h5A);

        // Reset mid-frame (rx_valid still set from the previous frame)
        write_tx(8'h42);
        cs_low();
        xfer(8'h99, 3, mi);
        rst = 1'b1;
        #1;
        chk("midrst_miso", miso_o, 1'b1);
        chk("midrst_oe", miso_oe_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_tx_ready", tx_ready_o, 1'b1);
        chk("midrst_rx_valid", rx_valid_o, 1'b0);
        chk("midrst_rx_data", rx_data_o, 8'h00);
        cs_n = 1'b1;
        sclk = cpol;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        write_tx(8'hE7);
        exp_rx.push_back(8'h3C);
        cs_low();
        xfer(8'h3C, 8, mi);
        cs_high();
        chk("postrst_miso_byte", mi, 8'hE7);
        chk("postrst_rx_valid", rx_valid_o, 1'b1);
        chk("postrst_rx_data", rx_data_o, 8'h3C);
        ack_rx();

        wait_clk(4);
        chk("scoreboard_drained", exp_rx.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
